// File: rtl/fsk_bit_recovery.sv
// -----------------------------------------------------------------------------
// fsk_bit_recovery
//
// Cleans the raw per-sample bit decision coming out of fsk_demodulator,
// recovers symbol timing from the cleaned transitions, hunts for a sync word,
// reads a length byte and delivers the following payload bytes through a
// single-entry valid/ready output buffer.
//
// Ports:
//   clk         in   1  sample clock, one demodulator sample per cycle
//   reset       in   1  asynchronous reset, active low
//   demod_in    in   1  raw bit decision from the demodulator
//   byte_out    out  8  payload byte, meaningful while byte_valid = 1
//   byte_valid  out  1  output buffer holds a byte
//   byte_ready  in   1  consumer takes the byte on byte_valid & byte_ready
//   locked      out  1  frame FSM is reading a length or payload
//   overrun     out  1  one-cycle pulse when a completed byte had to be dropped
// -----------------------------------------------------------------------------
module fsk_bit_recovery #(
    parameter int         SAMPLES_PER_BIT = 1024,
    parameter int         GLITCH_LEN      = 15,
    parameter logic [7:0] SYNC_WORD       = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       demod_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       overrun
);

    localparam int PHASE_W = $clog2(SAMPLES_PER_BIT);
    localparam int GCNT_W  = $clog2(GLITCH_LEN + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(SAMPLES_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_STROBE = PHASE_W'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [GCNT_W-1:0]  GCNT_LAST    = GCNT_W'(GLITCH_LEN - 1);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD
    } state_t;

    logic                demod_q;
    logic                level;
    logic                level_toggle;
    logic [GCNT_W-1:0]   glitch_cnt;
    logic [PHASE_W-1:0]  phase;
    logic                strobe;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          shift_reg;
    logic [7:0]          shift_nxt;
    logic [7:0]          shifted;
    logic [2:0]          bit_cnt;
    logic [2:0]          bit_cnt_nxt;
    logic [7:0]          byte_cnt;
    logic [7:0]          byte_cnt_nxt;
    logic                payload_done;

    // The level flips on the cycle that would bring the disagreement count to
    // GLITCH_LEN, so a change held stable lands GLITCH_LEN cycles after it
    // reaches demod_q; shorter pulses are forgotten when the count clears.
    assign level_toggle = (demod_q != level) && (glitch_cnt == GCNT_LAST);

    // Input register and glitch filter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            demod_q    <= 1'b0;
            level      <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            demod_q <= demod_in;
            if (demod_q == level) begin
                glitch_cnt <= '0;
            end else if (level_toggle) begin
                level      <= ~level;
                glitch_cnt <= '0;
            end else begin
                glitch_cnt <= glitch_cnt + GCNT_W'(1);
            end
        end
    end

    // Symbol phase: a filtered edge realigns it to 0, otherwise it free-runs
    // so long runs of identical bits still produce one strobe per symbol.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (level_toggle) begin
            phase <= '0;
        end else if (phase == PHASE_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PHASE_W'(1);
        end
    end

    // Mid-symbol sample point; the registered level is used, so an edge that
    // lands in this same cycle still samples the pre-toggle value.
    assign strobe  = (phase == PHASE_STROBE);
    assign shifted = {shift_reg[6:0], level};

    // Frame FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
        end
    end

    // Frame FSM next-state logic. bit_cnt wraps 7 -> 0 by itself, so it is
    // already zero whenever a new 8-bit field starts. Every return to HUNT
    // clears the shift register so sync cannot match on payload leftovers.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_reg;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        payload_done = 1'b0;
        if (strobe) begin
            shift_nxt = shifted;
            case (state)
                HUNT: begin
                    if (shifted == SYNC_WORD) begin
                        state_nxt   = LEN;
                        bit_cnt_nxt = '0;
                    end
                end
                LEN: begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shifted == 8'd0) begin
                            state_nxt = HUNT;
                            shift_nxt = '0;
                        end else begin
                            state_nxt    = PAYLOAD;
                            byte_cnt_nxt = shifted;
                        end
                    end
                end
                PAYLOAD: begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        payload_done = 1'b1;
                        byte_cnt_nxt = byte_cnt - 8'd1;
                        if (byte_cnt == 8'd1) begin
                            state_nxt = HUNT;
                            shift_nxt = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    shift_nxt = '0;
                end
            endcase
        end
    end

    assign locked = (state != HUNT);

    // Single-entry output buffer. A byte that completes while the buffer is
    // still full and not being taken is dropped; the FSM counts it anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (payload_done) begin
                if (!byte_valid || byte_ready) begin
                    byte_out   <= shifted;
                    byte_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fsk_bit_recovery.sv
// -----------------------------------------------------------------------------
// tb_fsk_bit_recovery
//
// Drives NRZ frames into two fsk_bit_recovery instances (16/3 and the default
// 1024/15). Expected outputs for every cycle come from the frame layout alone:
// a strobe for frame bit n falls GLITCH_LEN + SAMPLES_PER_BIT/2 cycles after
// the start of that bit, so lock, byte and overrun times are plain arithmetic.
// -----------------------------------------------------------------------------
module tb_fsk_bit_recovery;

    logic       clk = 1'b0;
    logic       reset;
    logic       demod_in;
    logic       byte_ready;
    logic [7:0] byte_out_a;
    logic       byte_valid_a;
    logic       locked_a;
    logic       overrun_a;
    logic [7:0] byte_out_b;
    logic       byte_valid_b;
    logic       locked_b;
    logic       overrun_b;

    int tests_run    = 0;
    int tests_failed = 0;

    int         spb;
    int         glen;
    bit         use_default;
    logic [7:0] fb [0:15];
    int         nbytes;

    always #5 clk = ~clk;

    fsk_bit_recovery #(
        .SAMPLES_PER_BIT(16),
        .GLITCH_LEN     (3),
        .SYNC_WORD      (8'hA5)
    ) dut_small (
        .clk       (clk),
        .reset     (reset),
        .demod_in  (demod_in),
        .byte_out  (byte_out_a),
        .byte_valid(byte_valid_a),
        .byte_ready(byte_ready),
        .locked    (locked_a),
        .overrun   (overrun_a)
    );

    fsk_bit_recovery dut_default (
        .clk       (clk),
        .reset     (reset),
        .demod_in  (demod_in),
        .byte_out  (byte_out_b),
        .byte_valid(byte_valid_b),
        .byte_ready(byte_ready),
        .locked    (locked_b),
        .overrun   (overrun_b)
    );

    // Compares the selected instance's outputs with the expected values.
    task automatic checkOutput(input string tag, input logic [7:0] exp_byte,
                               input logic exp_valid, input logic exp_locked,
                               input logic exp_overrun, input bit check_byte);
        logic [7:0] o_byte;
        logic       o_valid;
        logic       o_locked;
        logic       o_overrun;
        o_byte    = use_default ? byte_out_b   : byte_out_a;
        o_valid   = use_default ? byte_valid_b : byte_valid_a;
        o_locked  = use_default ? locked_b     : locked_a;
        o_overrun = use_default ? overrun_b    : overrun_a;
        tests_run++;
        assert (o_valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL %s byte_valid got %b expected %b at %0t", tag, o_valid, exp_valid, $time);
        end
        tests_run++;
        assert (o_locked === exp_locked) else begin
            tests_failed++;
            $error("[TB] FAIL %s locked got %b expected %b at %0t", tag, o_locked, exp_locked, $time);
        end
        tests_run++;
        assert (o_overrun === exp_overrun) else begin
            tests_failed++;
            $error("[TB] FAIL %s overrun got %b expected %b at %0t", tag, o_overrun, exp_overrun, $time);
        end
        if (check_byte) begin
            tests_run++;
            assert (o_byte === exp_byte) else begin
                tests_failed++;
                $error("[TB] FAIL %s byte_out got %h expected %h at %0t", tag, o_byte, exp_byte, $time);
            end
        end
    endtask

    // One sample: drive before the edge, observe 1 time unit after it.
    task automatic tick(input logic v);
        demod_in = v;
        @(posedge clk);
        #1;
    endtask

    // Sends idle zeros then the frame held in fb[0:nbytes-1].
    // mode 0: byte_ready high; mode 1: byte_ready low for the whole frame;
    // mode 2: byte_ready low until the second payload byte completes.
    // abort_r >= 0 asserts reset at that frame cycle and abandons the frame.
    task automatic applyStimulus(input int mode, input bit glitches, input int abort_r);
        int         nbits;
        int         lenb;
        int         lock_end;
        int         so;
        int         idle;
        int         bit_idx;
        int         off;
        int         g_off;
        int         g_len;
        int         ci;
        int         c0;
        int         c1;
        logic       v;
        logic       e_valid;
        logic       e_locked;
        logic       e_overrun;
        logic [7:0] e_byte;
        bit         chk;

        lenb     = int'(fb[1]);
        nbits    = 8 * nbytes;
        lock_end = (lenb == 0) ? 15 : 15 + 8 * lenb;
        so       = glen + spb / 2;
        c0       = 23 * spb + so;
        c1       = 31 * spb + so;
        g_off    = 0;
        g_len    = 0;

        idle = $urandom_range(1, 3);
        for (int i = 0; i < idle * spb; i++) begin
            tick(1'b0);
            checkOutput("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        byte_ready = (mode == 0);

        for (int r = 0; r < nbits * spb; r++) begin
            bit_idx = r / spb;
            off     = r % spb;
            if (off == 0) begin
                g_len = $urandom_range(1, glen - 1);
                g_off = $urandom_range(glen + 1, spb - g_len - 1);
            end
            v = fb[bit_idx / 8][7 - (bit_idx % 8)];
            if (glitches && off >= g_off && off < g_off + g_len) v = ~v;

            if (r == abort_r) begin
                reset = 1'b0;
                #1;
                checkOutput("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
                for (int i = 0; i < 3; i++) begin
                    tick(v);
                    checkOutput("midframe_reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                reset = 1'b1;
                return;
            end
            if (mode == 2 && r == c1) byte_ready = 1'b1;

            tick(v);

            e_locked  = (r >= 7 * spb + so) && (r < lock_end * spb + so);
            e_valid   = 1'b0;
            e_overrun = 1'b0;
            e_byte    = 8'h00;
            chk       = 1'b0;
            if (mode == 2) begin
                if (r >= c0 && r <= c1) begin
                    e_valid = 1'b1;
                    e_byte  = (r < c1) ? fb[2] : fb[3];
                    chk     = 1'b1;
                end
            end else begin
                for (int i = 0; i < lenb; i++) begin
                    ci = (23 + 8 * i) * spb + so;
                    if (mode == 0 && r == ci) begin
                        e_valid = 1'b1;
                        e_byte  = fb[2 + i];
                        chk     = 1'b1;
                    end
                    if (mode == 1 && i == 0 && r >= ci) begin
                        e_valid = 1'b1;
                        e_byte  = fb[2];
                        chk     = 1'b1;
                    end
                    if (mode == 1 && i > 0 && r == ci) e_overrun = 1'b1;
                end
            end
            checkOutput("frame", e_byte, e_valid, e_locked, e_overrun, chk);
        end

        if (mode == 1) begin
            byte_ready = 1'b1;
            tick(1'b0);
            checkOutput("backpressure_accept", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(1'b0);
            checkOutput("backpressure_after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        byte_ready = 1'b1;
    endtask

    // Loads the basic A5 02 3C C3 frame.
    task automatic loadBasic();
        fb[0]  = 8'hA5;
        fb[1]  = 8'h02;
        fb[2]  = 8'h3C;
        fb[3]  = 8'hC3;
        nbytes = 4;
    endtask

    initial begin
        reset       = 1'b0;
        demod_in    = 1'b0;
        byte_ready  = 1'b1;
        use_default = 1'b0;
        spb         = 16;
        glen        = 3;

        // Reset held while the line toggles.
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 1)));
            checkOutput("reset_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b1;

        // Basic frame, then with injected glitches.
        loadBasic();
        applyStimulus(0, 1'b0, -1);
        applyStimulus(0, 1'b1, -1);

        // Backpressure: overrun on C3, 3C held.
        applyStimulus(1, 1'b0, -1);

        // Ready raised in the same cycle the second byte completes.
        applyStimulus(2, 1'b0, -1);

        // Zero length frame followed by 3C.
        fb[0]  = 8'hA5;
        fb[1]  = 8'h00;
        fb[2]  = 8'h3C;
        nbytes = 3;
        applyStimulus(0, 1'b0, -1);

        // Reset during the first payload bit, then a fresh frame.
        loadBasic();
        applyStimulus(0, 1'b0, 16 * 16 + 5);
        fb[0]  = 8'hA5;
        fb[1]  = 8'h01;
        fb[2]  = 8'h7E;
        nbytes = 3;
        applyStimulus(0, 1'b0, -1);

        // Random frames with random glitches.
        for (int k = 0; k < 6; k++) begin
            fb[0] = 8'hA5;
            fb[1] = 8'($urandom_range(1, 4));
            for (int i = 0; i < int'(fb[1]); i++) fb[2 + i] = 8'($urandom_range(0, 255));
            nbytes = 2 + int'(fb[1]);
            applyStimulus(0, 1'b1, -1);
        end

        // Default parameters (1024/15) on the second instance.
        reset = 1'b0;
        tick(1'b0);
        tick(1'b0);
        use_default = 1'b1;
        spb         = 1024;
        glen        = 15;
        checkOutput("default_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        loadBasic();
        applyStimulus(0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fsk_bit_recovery.md
# fsk_bit_recovery

Downstream stage of `fsk_demodulator`. Takes its raw per-sample bit decision `data_out` and removes short glitches. It recovers symbol timing from the cleaned transitions, finds a sync word, and delivers payload bytes over a single-entry valid/ready output buffer. One demodulator sample arrives per `clk`, and each symbol lasts `SAMPLES_PER_BIT` samples.

## Interface
- `SAMPLES_PER_BIT`, default 1024: samples per symbol. Must be even and ≥ 8.
- `GLITCH_LEN`, default 15: consecutive disagreeing samples required before the filtered level changes. Range 1 .. `SAMPLES_PER_BIT`/4.
- `SYNC_WORD`, default 8'hA5: frame start pattern, MSB first.

Ports:
- `clk` — in, 1: sample clock; the only clock.
- `reset` — in, 1: asynchronous, active-low reset.
- `demod_in` — in, 1: raw bit decision from `fsk_demodulator.data_out`.
- `byte_out` — out, 8: payload byte, valid while `byte_valid` = 1.
- `byte_valid` — out, 1: a byte is held in the output buffer.
- `byte_ready` — in, 1: the consumer accepts the byte when `byte_valid` & `byte_ready`.
- `locked` — out, 1: set while the FSM is in LEN or PAYLOAD.
- `overrun` — out, 1: one-cycle pulse when a completed payload byte is dropped.

## Operation
- **Reset.** Active (`reset` = 0) immediately clears everything: `byte_out` = 0, `byte_valid` = 0, `locked` = 0, `overrun` = 0, filtered level = 0, glitch counter = 0, phase = 0, shift register = 0, bit count = 0, byte count = 0, FSM = HUNT.
- **Input register.** `demod_in` is registered once before the glitch filter.
- **Glitch filter.**
  - While the registered input ≠ the filtered level, a counter increments; it clears to 0 whenever they agree.
  - When the counter reaches `GLITCH_LEN`, the filtered level toggles and the counter clears.
  - Pulses shorter than `GLITCH_LEN` samples never reach the filtered level.
- **Phase counter.**
  - Width is clog2(`SAMPLES_PER_BIT`).
  - It counts 0 .. `SAMPLES_PER_BIT`-1 and wraps to 0.
  - Any filtered-level toggle forces phase to 0 on that edge; this overrides the increment and the wrap.
  - Between edges it free-runs, including after reset before the first edge.
- **Bit strobe.** Asserted in the cycle where phase = `SAMPLES_PER_BIT`/2 - 1. The filtered level in that cycle is the received bit.
- **Frame FSM.** Acts on strobes only; bits are MSB first.
  - HUNT: each strobe shifts the bit into an 8-bit shift register. When the updated register equals `SYNC_WORD`, go to LEN with bit count = 0.
  - LEN: collect 8 bits into a length L.
    - L = 0: go to HUNT.
    - Otherwise: byte count = L, go to PAYLOAD.
  - PAYLOAD: collect 8 bits, then offer the byte to the output buffer and decrement the byte count. When the count reaches 0, go to HUNT.
  - On entering HUNT, the shift register clears to 0, so sync cannot match on stale bits.
- **Output buffer** (when a payload byte completes):
  - If `byte_valid` = 0, or `byte_valid` = 1 and `byte_ready` = 1 in the same cycle: load `byte_out` and keep or set `byte_valid` = 1.
  - If `byte_valid` = 1 and `byte_ready` = 0: drop the new byte, keep the old byte, and pulse `overrun`. The FSM still counts the dropped byte.
  - `byte_valid` clears on a `byte_valid` & `byte_ready` cycle when no new byte loads.
- **Out-of-frame bits.** The length byte and the sync bits are never output.

## Timing
- **Filter latency.** A `demod_in` change held stable reaches the filtered level `GLITCH_LEN`+1 cycles later: 1 cycle of input register plus `GLITCH_LEN` of counting.
- **Sampling point.** The strobe falls `SAMPLES_PER_BIT`/2 - 1 cycles after the filtered edge that realigns phase, i.e. mid-symbol of the filtered stream.
- **Missing edges.** Runs of identical bits keep their spacing through free-running phase wrap; each run produces one strobe per `SAMPLES_PER_BIT` cycles.
- **`locked`.** Rises the cycle after the strobe that completes `SYNC_WORD`. Falls the cycle after the strobe completing the last payload byte, or completing a length byte of 0.
- **Byte output.** `byte_valid` and `byte_out` update the cycle after the strobe of a payload byte's 8th bit.
- **`overrun`.** High for exactly that one cycle.
- **Handshake.** `byte_out` is stable while `byte_valid` = 1 and `byte_ready` = 0. Combinational paths from `byte_ready` to outputs are allowed only within the buffer load/clear logic; there is no combinational path from `demod_in`.
- **Edge coincident with wrap.** The edge wins and phase = 0.
- **Edge in the strobe cycle.** Sampling uses the pre-toggle filtered level, and phase goes to 0.

## Test plan
Benches use `SAMPLES_PER_BIT` = 16, `GLITCH_LEN` = 3 unless stated. Stimulus drives `demod_in` as NRZ, 16 cycles per bit.
- **Reset hold.** Hold `reset` = 0 for 100 cycles while toggling `demod_in` -> `byte_out` = 00, `byte_valid` = 0, `locked` = 0, `overrun` = 0 throughout.
- **Basic frame.** Idle 0s, then A5 02 3C C3, with `byte_ready` = 1 -> exactly two `byte_valid` cycles carrying 3C then C3. `locked` rises 1 cycle after the sync strobe and falls 1 cycle after the C3 last-bit strobe.
- **Glitch immunity.** Basic frame with 2-cycle inverted pulses injected at phase 4 of every bit -> identical output: 3C, C3, no extra bytes.
- **Backpressure.** Basic frame with `byte_ready` = 0 until the frame ends -> `byte_out` holds 3C and `overrun` pulses once at C3 completion. Raising `byte_ready` then yields a single 3C accept, after which `byte_valid` = 0.
- **Zero length.** Frame A5 00 followed by 3C -> no `byte_valid`; `locked` high for 8 bit periods (128 cycles), then FSM back in HUNT.
- **Mid-frame reset.** Assert `reset` = 0 during the first payload bit -> all outputs 0 within the same cycle. After release, a fresh A5 01 7E delivers exactly 7E. Also rerun the basic frame with default parameters (1024/15).
